// File: rtl/mem_stage_ctrl_pkg.sv
// Shared ISA constants and state encoding for the MEM stage of the 16-bit core.
package mem_stage_ctrl_pkg;

    localparam logic [4:0] OP_ST  = 5'b10000;
    localparam logic [4:0] OP_LD  = 5'b10001;
    localparam logic [4:0] OP_STU = 5'b10011;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_STU);
    endfunction

    function automatic logic is_load_op(input logic [4:0] op);
        return op == OP_LD;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_req_fsm.sv
// Request FSM: issues one cache strobe per memory op, tracks the outstanding request,
// raises the pipeline stall and reports when/how the request completes.
module mem_req_fsm
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_ld,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic          req_wb_en,
    input  logic [RW-1:0] req_wb_reg,
    input  logic          c_done,
    input  logic          c_stall,
    input  logic          c_err,
    output logic          mem_stall,
    output logic [DW-1:0] c_addr,
    output logic [DW-1:0] c_wdata,
    output logic          c_rd,
    output logic          c_wr,
    output logic          cmp,
    output logic          cmp_err,
    output logic          cmp_ld,
    output logic [DW-1:0] cmp_addr,
    output logic          cmp_wb_en,
    output logic [RW-1:0] cmp_wb_reg
);

    state_t        state_reg;
    logic [DW-1:0] cap_addr_reg;
    logic [DW-1:0] cap_wdata_reg;
    logic          cap_ld_reg;
    logic          cap_wb_en_reg;
    logic [RW-1:0] cap_wb_reg_reg;
    logic          issue;

    // Strobes and stall are combinational so a same-cycle hit costs no bubble.
    always_comb begin
        mem_stall  = 1'b0;
        c_rd       = 1'b0;
        c_wr       = 1'b0;
        c_addr     = req_addr;
        c_wdata    = req_wdata;
        cmp        = 1'b0;
        cmp_err    = 1'b0;
        cmp_ld     = req_ld;
        cmp_addr   = req_addr;
        cmp_wb_en  = req_wb_en;
        cmp_wb_reg = req_wb_reg;
        issue      = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_addr[0]) begin
                            cmp     = 1'b1;
                            cmp_err = 1'b1;
                        end else if (c_stall) begin
                            mem_stall = 1'b1;
                        end else begin
                            issue = 1'b1;
                            c_rd  = req_ld;
                            c_wr  = !req_ld;
                            if (c_done) begin
                                cmp     = 1'b1;
                                cmp_err = c_err;
                            end else begin
                                mem_stall = 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    c_addr     = cap_addr_reg;
                    c_wdata    = cap_wdata_reg;
                    cmp_ld     = cap_ld_reg;
                    cmp_addr   = cap_addr_reg;
                    cmp_wb_en  = cap_wb_en_reg;
                    cmp_wb_reg = cap_wb_reg_reg;
                    if (c_done || c_err) begin
                        cmp     = 1'b1;
                        cmp_err = c_err;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cap_addr_reg   <= '0;
            cap_wdata_reg  <= '0;
            cap_ld_reg     <= 1'b0;
            cap_wb_en_reg  <= 1'b0;
            cap_wb_reg_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (issue) begin
                        cap_addr_reg   <= req_addr;
                        cap_wdata_reg  <= req_wdata;
                        cap_ld_reg     <= req_ld;
                        cap_wb_en_reg  <= req_wb_en;
                        cap_wb_reg_reg <= req_wb_reg;
                        if (!c_done) state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cmp) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: decodes memory ops, drives the request FSM and holds the MEM/WB registers.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [15:0]   ex_instr,
    input  logic [DW-1:0] ex_alu_out,
    input  logic [DW-1:0] ex_st_data,
    input  logic          ex_wb_en,
    input  logic [RW-1:0] ex_wb_reg,
    output logic          mem_stall,
    output logic [DW-1:0] c_addr,
    output logic [DW-1:0] c_wdata,
    output logic          c_rd,
    output logic          c_wr,
    input  logic [DW-1:0] c_rdata,
    input  logic          c_done,
    input  logic          c_stall,
    input  logic          c_err,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic          wb_en,
    output logic [RW-1:0] wb_reg,
    output logic          wb_err
);

    logic          is_mem;
    logic          is_ld;
    logic          cmp;
    logic          cmp_err;
    logic          cmp_ld;
    logic [DW-1:0] cmp_addr;
    logic          cmp_wb_en;
    logic [RW-1:0] cmp_wb_reg;
    logic          unused_instr_bits;

    assign is_mem            = is_mem_op(ex_instr[15:11]);
    assign is_ld             = is_load_op(ex_instr[15:11]);
    assign unused_instr_bits = ^ex_instr[10:0];

    mem_req_fsm #(.DW(DW), .RW(RW)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (ex_valid && is_mem),
        .req_ld     (is_ld),
        .req_addr   (ex_alu_out),
        .req_wdata  (ex_st_data),
        .req_wb_en  (ex_wb_en),
        .req_wb_reg (ex_wb_reg),
        .c_done     (c_done),
        .c_stall    (c_stall),
        .c_err      (c_err),
        .mem_stall  (mem_stall),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_rd       (c_rd),
        .c_wr       (c_wr),
        .cmp        (cmp),
        .cmp_err    (cmp_err),
        .cmp_ld     (cmp_ld),
        .cmp_addr   (cmp_addr),
        .cmp_wb_en  (cmp_wb_en),
        .cmp_wb_reg (cmp_wb_reg)
    );

    // Anything that is neither a pass-through nor a completing request loads a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_en    <= 1'b0;
            wb_reg   <= '0;
            wb_err   <= 1'b0;
        end else if (ex_valid && !is_mem) begin
            wb_valid <= 1'b1;
            wb_data  <= ex_alu_out;
            wb_en    <= ex_wb_en;
            wb_reg   <= ex_wb_reg;
            wb_err   <= 1'b0;
        end else if (cmp) begin
            wb_valid <= 1'b1;
            wb_data  <= cmp_ld ? c_rdata : cmp_addr;
            wb_en    <= cmp_err ? 1'b0 : cmp_wb_en;
            wb_reg   <= cmp_wb_reg;
            wb_err   <= cmp_err;
        end else begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_en    <= 1'b0;
            wb_reg   <= '0;
            wb_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomised bench for mem_stage_ctrl: each instruction is planned as (stall cycles,
// latency, error) and the expected per-cycle outputs are derived from that plan.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_instr;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_st_data;
    logic        ex_wb_en;
    logic [2:0]  ex_wb_reg;
    logic        mem_stall;
    logic [15:0] c_addr;
    logic [15:0] c_wdata;
    logic        c_rd;
    logic        c_wr;
    logic [15:0] c_rdata;
    logic        c_done;
    logic        c_stall;
    logic        c_err;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic        wb_err;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_instr   (ex_instr),
        .ex_alu_out (ex_alu_out),
        .ex_st_data (ex_st_data),
        .ex_wb_en   (ex_wb_en),
        .ex_wb_reg  (ex_wb_reg),
        .mem_stall  (mem_stall),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_rd       (c_rd),
        .c_wr       (c_wr),
        .c_rdata    (c_rdata),
        .c_done     (c_done),
        .c_stall    (c_stall),
        .c_err      (c_err),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_err     (wb_err)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        en;
        logic [2:0]  r;
        logic        e;
    } wb_t;

    localparam logic [4:0] LD   = 5'b10001;
    localparam logic [4:0] ST   = 5'b10000;
    localparam logic [4:0] STU  = 5'b10011;
    localparam logic [4:0] ADDI = 5'b01000;

    wb_t         exp_wb = '0;
    wb_t         pend_wb = '0;
    logic        zero_chk = 1'b1;
    logic        pend_zero = 1'b1;
    logic        exp_stall = 1'b0;
    logic        exp_rd = 1'b0;
    logic        exp_wr = 1'b0;
    logic        exp_chk_addr = 1'b0;
    logic [15:0] exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_cnt = 0;
    int          strobe_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Single compare process: every cycle, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("mem_stall", 16'(mem_stall), 16'(exp_stall));
            chk("c_rd", 16'(c_rd), 16'(exp_rd));
            chk("c_wr", 16'(c_wr), 16'(exp_wr));
            if (exp_chk_addr) begin
                chk("c_addr", c_addr, exp_addr);
                chk("c_wdata", c_wdata, exp_wdata);
            end
            chk("wb_valid", 16'(wb_valid), 16'(exp_wb.v));
            if (exp_wb.v || zero_chk) begin
                chk("wb_en", 16'(wb_en), 16'(exp_wb.en));
                chk("wb_reg", 16'(wb_reg), 16'(exp_wb.r));
                chk("wb_err", 16'(wb_err), 16'(exp_wb.e));
                if (!exp_wb.e) chk("wb_data", wb_data, exp_wb.d);
            end
            if (mem_stall) stall_cnt++;
            if (c_rd || c_wr) strobe_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        exp_wb       = pend_wb;
        pend_wb      = '0;
        zero_chk     = pend_zero;
        pend_zero    = 1'b0;
        exp_stall    = 1'b0;
        exp_rd       = 1'b0;
        exp_wr       = 1'b0;
        exp_chk_addr = 1'b0;
        rst          = 1'b0;
        c_stall      = 1'b0;
        c_done       = 1'b0;
        c_err        = 1'b0;
        c_rdata      = 16'($urandom);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            rst       = 1'b1;
            ex_valid  = 1'b0;
            pend_zero = 1'b1;
        end
    endtask

    // One instruction from EX/MEM entry to the cycle it completes; the upstream
    // pipe is frozen, so ex_* stay put for the whole window.
    task automatic run_instr(input logic v, input logic [4:0] op, input logic [15:0] addr,
                             input logic [15:0] data, input logic en, input logic [2:0] rg,
                             input int s, input int l, input logic err, input logic [15:0] rdata);
        logic mem;
        logic ld;
        wb_t  res;
        mem = (op == LD) || (op == ST) || (op == STU);
        ld  = (op == LD);
        res = err ? wb_t'{1'b1, 16'h0000, 1'b0, rg, 1'b1}
                  : wb_t'{1'b1, (ld ? rdata : addr), en, rg, 1'b0};
        cyc();
        ex_valid   = v;
        ex_instr   = {op, 11'($urandom)};
        ex_alu_out = addr;
        ex_st_data = data;
        ex_wb_en   = en;
        ex_wb_reg  = rg;
        if (!v || !mem) begin
            c_done = 1'($urandom_range(0, 1));
            if (v) pend_wb = '{1'b1, addr, en, rg, 1'b0};
            return;
        end
        if (addr[0]) begin
            pend_wb = '{1'b1, 16'h0000, 1'b0, rg, 1'b1};
            return;
        end
        for (int k = 0; k <= s + l; k++) begin
            if (k > 0) cyc();
            if (k < s) begin
                c_stall   = 1'b1;
                exp_stall = 1'b1;
            end else begin
                exp_chk_addr = 1'b1;
                exp_addr     = addr;
                exp_wdata    = data;
                if (k == s) begin
                    exp_rd    = ld;
                    exp_wr    = !ld;
                    exp_stall = (l != 0);
                    c_done    = (l == 0);
                    c_err     = (l == 0) && err;
                    c_rdata   = rdata;
                    if (l == 0) pend_wb = res;
                end else begin
                    c_stall = 1'($urandom_range(0, 1));
                    if (k == s + l) begin
                        if (err) begin
                            c_err  = 1'b1;
                            c_done = 1'($urandom_range(0, 1));
                        end else begin
                            c_done = 1'b1;
                        end
                        c_rdata = rdata;
                        pend_wb = res;
                    end else begin
                        exp_stall = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic bubble_then_sample();
        run_instr(1'b0, ADDI, 16'h0, 16'h0, 1'b0, 3'd0, 0, 0, 1'b0, 16'h0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int s0;
        int t0;
        logic [4:0]  op;
        logic [15:0] a;
        logic        en;
        rst = 1'b1; ex_valid = 1'b0; ex_instr = '0; ex_alu_out = '0; ex_st_data = '0;
        ex_wb_en = 1'b0; ex_wb_reg = '0; c_rdata = '0; c_done = 1'b0; c_stall = 1'b0; c_err = 1'b0;
        do_reset(2);

        // 1: ADDI pass-through
        s0 = stall_cnt;
        run_instr(1'b1, ADDI, 16'h0042, 16'h0, 1'b1, 3'd2, 0, 0, 1'b0, 16'h0);
        bubble_then_sample();
        chk("lit_addi_data", wb_data, 16'h0042);
        chk("lit_addi_stall", 16'(stall_cnt - s0), 16'd0);

        // 2: LD hit
        s0 = stall_cnt; t0 = strobe_cnt;
        run_instr(1'b1, LD, 16'h0010, 16'h0, 1'b1, 3'd5, 0, 0, 1'b0, 16'hBEEF);
        bubble_then_sample();
        chk("lit_ld_hit_data", wb_data, 16'hBEEF);
        chk("lit_ld_hit_stall", 16'(stall_cnt - s0), 16'd0);
        chk("lit_ld_hit_strobe", 16'(strobe_cnt - t0), 16'd1);

        // 3: ST with done three cycles after the strobe
        s0 = stall_cnt; t0 = strobe_cnt;
        run_instr(1'b1, ST, 16'h0020, 16'h1234, 1'b0, 3'd0, 0, 3, 1'b0, 16'h0);
        bubble_then_sample();
        chk("lit_st_stall", 16'(stall_cnt - s0), 16'd3);
        chk("lit_st_strobe", 16'(strobe_cnt - t0), 16'd1);
        chk("lit_st_data", wb_data, 16'h0020);

        // 4: LD behind a busy cache
        s0 = stall_cnt; t0 = strobe_cnt;
        run_instr(1'b1, LD, 16'h0030, 16'h0, 1'b1, 3'd1, 2, 1, 1'b0, 16'hCAFE);
        bubble_then_sample();
        chk("lit_ld_busy_stall", 16'(stall_cnt - s0), 16'd3);
        chk("lit_ld_busy_data", wb_data, 16'hCAFE);

        // 5: misaligned LD, then c_err while waiting
        t0 = strobe_cnt;
        run_instr(1'b1, LD, 16'h0021, 16'h0, 1'b1, 3'd3, 0, 0, 1'b0, 16'h0);
        bubble_then_sample();
        chk("lit_misalign_err", 16'(wb_err), 16'd1);
        chk("lit_misalign_en", 16'(wb_en), 16'd0);
        chk("lit_misalign_strobe", 16'(strobe_cnt - t0), 16'd0);
        run_instr(1'b1, LD, 16'h0050, 16'h0, 1'b1, 3'd4, 0, 2, 1'b1, 16'h0);
        bubble_then_sample();
        chk("lit_werr_err", 16'(wb_err), 16'd1);

        // 6: reset while a load is outstanding; a late done must be ignored
        cyc();
        ex_valid = 1'b1; ex_instr = {LD, 11'h0}; ex_alu_out = 16'h0040; ex_wb_en = 1'b1; ex_wb_reg = 3'd6;
        exp_rd = 1'b1; exp_stall = 1'b1; exp_chk_addr = 1'b1; exp_addr = 16'h0040; exp_wdata = ex_st_data;
        cyc();
        exp_stall = 1'b1; exp_chk_addr = 1'b1;
        cyc();
        rst = 1'b1; pend_zero = 1'b1;
        cyc();
        ex_valid = 1'b0; c_done = 1'b1; c_rdata = 16'hDEAD;
        s0 = stall_cnt;
        run_instr(1'b1, ADDI, 16'h0077, 16'h0, 1'b1, 3'd1, 0, 0, 1'b0, 16'h0);
        bubble_then_sample();
        chk("lit_after_rst_data", wb_data, 16'h0077);
        chk("lit_after_rst_stall", 16'(stall_cnt - s0), 16'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: op = LD;
                1: op = ST;
                2: op = STU;
                default: begin
                    op = 5'($urandom);
                    while (op == LD || op == ST || op == STU) op = 5'($urandom);
                end
            endcase
            a  = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
            en = (op == ST) ? 1'b0 : 1'($urandom_range(0, 1));
            run_instr(($urandom_range(0, 9) != 0), op, a, 16'($urandom), en, 3'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                      ($urandom_range(0, 7) == 0), 16'($urandom));
        end
        cyc();
        ex_valid = 1'b0;
        cyc();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
